// File: rtl/router_pkg.sv
// Shared constants and types for the Kalman-filter operand router.
package router_pkg;

  // Select codes above the source range, as offsets from NSRC.
  localparam int SEL_ZERO_OFS = 0;
  localparam int SEL_ONES_OFS = 1;
  localparam int SEL_LAST_OFS = 2;

  typedef enum logic [1:0] {
    IMM_ZERO = 2'd0,
    IMM_P1   = 2'd1,
    IMM_M1   = 2'd2,
    IMM_EXT  = 2'd3
  } imm_sel_e;

  typedef enum logic [1:0] {
    SB_EMPTY = 2'd0,
    SB_ONE   = 2'd1,
    SB_FULL  = 2'd2
  } skid_state_e;

  // Payload layout: {R, S, I, msb_r, msb_s}.
  function automatic int payload_w(input int w);
    return 3 * w + 2;
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry valid/ready skid buffer: an output register plus one skid register.
// Handshake: a word moves on any edge where its valid and the receiving ready
// are both high; out_data_o is held stable while out_valid_o && !out_ready_i.
module skid_buf2
  import router_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid_i,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic [1:0]    state_o
);

  skid_state_e   state_q, state_d;
  logic [DW-1:0] out_q, out_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          accept;

  assign accept = in_valid_i && (state_q != SB_FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SB_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      SB_EMPTY: begin
        if (accept) begin
          out_d   = in_data_i;
          state_d = SB_ONE;
        end
      end
      SB_ONE: begin
        if (out_ready_i) begin
          // Draining: a concurrent accept reloads the out register directly.
          if (accept) out_d = in_data_i;
          else        state_d = SB_EMPTY;
        end else if (accept) begin
          skid_d  = in_data_i;
          state_d = SB_FULL;
        end
      end
      SB_FULL: begin
        if (out_ready_i) begin
          out_d   = skid_q;
          state_d = SB_ONE;
        end
      end
      default: state_d = SB_EMPTY;
    endcase
  end

  assign out_valid_o = (state_q != SB_EMPTY);
  assign out_data_o  = out_q;
  assign state_o     = state_q;

endmodule

// File: rtl/router_pipe.sv
// Registered R/S/I operand router: combinational select/invert/immediate,
// last-result forwarding, and a 2-entry skid buffer toward the MAC stage.
module router_pipe
  import router_pkg::*;
#(
  parameter  int W    = 24,
  parameter  int NSRC = 4,
  parameter  int IMMW = 8,
  localparam int SELW = $clog2(NSRC) + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NSRC*W-1:0] src_r,
  input  logic [NSRC*W-1:0] src_s,
  input  logic [SELW-1:0]   sel_r,
  input  logic [SELW-1:0]   sel_s,
  input  logic              inv_r,
  input  logic              inv_s,
  input  logic [1:0]        sel_i,
  input  logic [IMMW-1:0]   imm,
  input  logic              res_valid,
  input  logic [W-1:0]      res_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      R,
  output logic [W-1:0]      S,
  output logic [W-1:0]      I,
  output logic              msb_r,
  output logic              msb_s
);

  localparam int PW = payload_w(W);

  logic [W-1:0]  last_res_q, last_res_d;
  logic [W-1:0]  op_r, op_s, op_i;
  logic [PW-1:0] pl_in, pl_out;
  logic [1:0]    buf_state;

  function automatic logic [W-1:0] pick(input logic [SELW-1:0]   sel,
                                        input logic [NSRC*W-1:0] src,
                                        input logic [W-1:0]      last,
                                        input logic              inv);
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (sel == SELW'(k)) v = src[k*W +: W];
    end
    if (sel == SELW'(NSRC + SEL_ONES_OFS)) v = '1;
    if (sel == SELW'(NSRC + SEL_LAST_OFS)) v = last;
    return inv ? ~v : v;
  endfunction

  // last_res_d doubles as the bypass value for a same-cycle write-back.
  assign last_res_d = res_valid ? res_data : last_res_q;

  always_ff @(posedge clk) begin
    if (rst) last_res_q <= '0;
    else     last_res_q <= last_res_d;
  end

  assign op_r = pick(sel_r, src_r, last_res_d, inv_r);
  assign op_s = pick(sel_s, src_s, last_res_d, inv_s);

  always_comb begin
    op_i = '0;
    case (sel_i)
      IMM_ZERO: op_i = '0;
      IMM_P1:   op_i = W'(1);
      IMM_M1:   op_i = '1;
      IMM_EXT:  op_i = W'($signed(imm));
      default:  op_i = '0;
    endcase
  end

  assign pl_in = {op_r, op_s, op_i, op_r[W-1], op_s[W-1]};

  skid_buf2 #(.DW(PW)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_data_i   (pl_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (pl_out),
    .state_o     (buf_state)
  );

  assign in_ready = (buf_state != SB_FULL) && !rst;
  assign {R, S, I, msb_r, msb_s} = pl_out;

endmodule

// File: tb/tb_router_pipe.sv
// Self-checking bench for router_pipe: directed scenarios plus a randomized
// stream scored against a FIFO-level reference model.
module tb_router_pipe;
  localparam int W    = 24;
  localparam int NSRC = 4;
  localparam int IMMW = 8;
  localparam int SELW = $clog2(NSRC) + 2;
  localparam int PW   = 3 * W + 2;
  localparam int LAST = NSRC + 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready;
  logic [NSRC*W-1:0] src_r, src_s;
  logic [SELW-1:0]   sel_r, sel_s;
  logic              inv_r, inv_s;
  logic [1:0]        sel_i;
  logic [IMMW-1:0]   imm;
  logic              res_valid;
  logic [W-1:0]      res_data;
  logic              out_valid, out_ready;
  logic [W-1:0]      R, S, I;
  logic              msb_r, msb_s;

  int errors = 0;
  int checks = 0;

  logic [W-1:0]  src_r_a [NSRC];
  logic [W-1:0]  src_s_a [NSRC];
  logic [PW-1:0] exp_q[$];
  logic [W-1:0]  model_last;
  logic [PW-1:0] obs;

  router_pipe #(.W(W), .NSRC(NSRC), .IMMW(IMMW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .src_r(src_r), .src_s(src_s), .sel_r(sel_r), .sel_s(sel_s),
    .inv_r(inv_r), .inv_s(inv_s), .sel_i(sel_i), .imm(imm),
    .res_valid(res_valid), .res_data(res_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .R(R), .S(S), .I(I), .msb_r(msb_r), .msb_s(msb_s)
  );

  // ---------------- clock / packing ----------------
  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NSRC; k++) begin
      src_r[k*W +: W] = src_r_a[k];
      src_s[k*W +: W] = src_s_a[k];
    end
  end

  assign obs = {R, S, I, msb_r, msb_s};

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] m_op(input bit use_s, input int code,
                                        input bit inv, input logic [W-1:0] last);
    logic [W-1:0] v;
    if (code < NSRC)          v = use_s ? src_s_a[code] : src_r_a[code];
    else if (code == NSRC+1)  v = {W{1'b1}};
    else if (code == NSRC+2)  v = last;
    else                      v = '0;
    return inv ? ~v : v;
  endfunction

  function automatic logic [W-1:0] m_imm(input int code, input logic [IMMW-1:0] f);
    logic signed [IMMW-1:0] fs;
    logic signed [W-1:0]    ext;
    fs  = f;
    ext = fs;
    case (code)
      0:       return '0;
      1:       return 1;
      2:       return {W{1'b1}};
      default: return ext;
    endcase
  endfunction

  function automatic logic [PW-1:0] m_bundle(input int sr, input int ss, input bit ir,
                                             input bit is, input int si,
                                             input logic [IMMW-1:0] f,
                                             input logic [W-1:0] last);
    logic [W-1:0] r, s, i;
    r = m_op(1'b0, sr, ir, last);
    s = m_op(1'b1, ss, is, last);
    i = m_imm(si, f);
    return {r, s, i, r[W-1], s[W-1]};
  endfunction

  // ---------------- driver: applies inputs and advances the model one edge ----------------
  task automatic drive(input bit v, input int sr, input int ss, input bit ir, input bit is,
                       input int si, input logic [IMMW-1:0] f, input bit ordy,
                       input bit rv, input logic [W-1:0] rd);
    bit fire, acc;
    logic [W-1:0] fwd;
    in_valid = v; sel_r = SELW'(sr); sel_s = SELW'(ss); inv_r = ir; inv_s = is;
    sel_i = 2'(si); imm = f; out_ready = ordy; res_valid = rv; res_data = rd;
    if (rst) begin
      exp_q.delete();
      model_last = '0;
    end else begin
      fire = (exp_q.size() > 0) && ordy;
      acc  = v && (exp_q.size() < 2);
      fwd  = rv ? rd : model_last;
      if (fire) void'(exp_q.pop_front());
      if (acc)  exp_q.push_back(m_bundle(sr, ss, ir, is, si, f, fwd));
      if (rv)   model_last = rd;
    end
  endtask

  task automatic drive_idle();
    drive(1'b0, 0, 0, 1'b0, 1'b0, 0, '0, 1'b1, 1'b0, '0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (obs !== '0) begin errors++; $display("FAIL rst_payload: got %h want 0", obs); end
    rst = 1'b0;
    drive_idle();
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_select_sweep();
    for (int k = 0; k < NSRC; k++) begin
      src_r_a[k] = 24'h123456 + W'(k);
      src_s_a[k] = 24'hABCDEF + W'(k);
    end
    for (int sr = 0; sr < (1 << SELW); sr++)
      for (int ss = 0; ss < (1 << SELW); ss++)
        for (int iv = 0; iv < 4; iv++)
          for (int si = 0; si < 3; si++) begin
            drive(1'b1, sr, ss, iv[0], iv[1], si, '0, 1'b1, 1'b0, '0);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL sweep_valid: got %b want 1", out_valid); end
            checks++;
            if (obs !== exp_q[0]) begin
              errors++;
              $display("FAIL sweep sr=%0d ss=%0d inv=%0d si=%0d: got %h want %h", sr, ss, iv, si, obs, exp_q[0]);
            end
          end
    drive_idle();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sweep_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_imm_ext();
    drive(1'b1, 0, 0, 1'b0, 1'b0, 3, 8'h80, 1'b1, 1'b0, '0);
    @(negedge clk);
    checks++; if (I !== 24'hFFFF80) begin errors++; $display("FAIL imm_neg: got %h want ffff80", I); end
    drive(1'b1, 0, 0, 1'b0, 1'b0, 3, 8'h7F, 1'b1, 1'b0, '0);
    @(negedge clk);
    checks++; if (I !== 24'h00007F) begin errors++; $display("FAIL imm_pos: got %h want 00007f", I); end
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_forwarding();
    drive(1'b1, LAST, NSRC, 1'b0, 1'b0, 0, '0, 1'b1, 1'b1, 24'h00C0DE);
    @(negedge clk);
    checks++; if (R !== 24'h00C0DE) begin errors++; $display("FAIL fwd_bypass: got %h want 00c0de", R); end
    checks++; if (S !== 24'h0) begin errors++; $display("FAIL fwd_s_zero: got %h want 0", S); end
    drive(1'b1, LAST, NSRC + 1, 1'b1, 1'b0, 0, '0, 1'b1, 1'b0, '0);
    @(negedge clk);
    checks++; if (R !== 24'hFF3F21) begin errors++; $display("FAIL fwd_inv: got %h want ff3f21", R); end
    checks++; if ({msb_r, msb_s} !== 2'b11) begin errors++; $display("FAIL fwd_msb: got %b want 11", {msb_r, msb_s}); end
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int n;
    bit acc_pred;
    n = 1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      acc_pred = (n <= 4) && (exp_q.size() < 2);
      drive(n <= 4, (n - 1) % NSRC, n % NSRC, 1'b0, 1'b0, 3, IMMW'(n), cyc >= 3, 1'b0, '0);
      if (acc_pred) n++;
      @(negedge clk);
      checks++;
      if (in_ready !== (exp_q.size() < 2)) begin
        errors++; $display("FAIL bp_in_ready cyc=%0d: got %b want %b", cyc, in_ready, exp_q.size() < 2);
      end
      checks++;
      if (out_valid !== (exp_q.size() > 0)) begin
        errors++; $display("FAIL bp_out_valid cyc=%0d: got %b want %b", cyc, out_valid, exp_q.size() > 0);
      end
      if (exp_q.size() > 0) begin
        checks++;
        if (obs !== exp_q[0]) begin errors++; $display("FAIL bp_order cyc=%0d: got %h want %h", cyc, obs, exp_q[0]); end
      end
      if (cyc == 2) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got %b want 0", in_ready); end
        checks++; if (I !== 24'd1) begin errors++; $display("FAIL bp_stall_hold: got %h want 000001", I); end
      end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_all_out: got %b want 0", out_valid); end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int k = 0; k < NSRC; k++) begin
        src_r_a[k] = W'($urandom);
        src_s_a[k] = W'($urandom);
      end
      drive($urandom_range(0, 3) != 0, $urandom_range(0, (1 << SELW) - 1),
            $urandom_range(0, (1 << SELW) - 1), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 3), IMMW'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, W'($urandom));
      @(negedge clk);
      checks++;
      if (in_ready !== (exp_q.size() < 2)) begin
        errors++; $display("FAIL rnd_in_ready cyc=%0d: got %b want %b", cyc, in_ready, exp_q.size() < 2);
      end
      checks++;
      if (out_valid !== (exp_q.size() > 0)) begin
        errors++; $display("FAIL rnd_out_valid cyc=%0d: got %b want %b", cyc, out_valid, exp_q.size() > 0);
      end
      if (exp_q.size() > 0) begin
        checks++;
        if (obs !== exp_q[0]) begin errors++; $display("FAIL rnd_payload cyc=%0d: got %h want %h", cyc, obs, exp_q[0]); end
      end
    end
    for (int cyc = 0; cyc < 4 && exp_q.size() > 0; cyc++) begin
      drive_idle();
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 0, 1, 1'b0, 1'b0, 1, '0, 1'b0, 1'b1, 24'h5A5A5A);
    @(negedge clk);
    drive(1'b1, 1, 2, 1'b0, 1'b0, 2, '0, 1'b0, 1'b0, '0);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_full: got %b want 0", in_ready); end
    rst = 1'b1;
    drive(1'b1, 2, 2, 1'b0, 1'b0, 2, '0, 1'b0, 1'b0, '0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
    checks++; if (obs !== '0) begin errors++; $display("FAIL mid_payload: got %h want 0", obs); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b want 0", in_ready); end
    rst = 1'b0;
    drive(1'b0, 0, 0, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0, '0);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_ghost: got %b want 0", out_valid); end
    drive(1'b1, LAST, LAST, 1'b0, 1'b0, 0, '0, 1'b1, 1'b0, '0);
    @(negedge clk);
    checks++; if (R !== 24'h0) begin errors++; $display("FAIL mid_last_cleared: got %h want 0", R); end
    drive_idle();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    model_last = '0;
    for (int k = 0; k < NSRC; k++) begin
      src_r_a[k] = '0;
      src_s_a[k] = '0;
    end
    test_reset();
    test_select_sweep();
    test_imm_ext();
    test_forwarding();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/router_pipe.md
# router_pipe

Registered, parametrised operand router for the Kalman-filter datapath, successor to the combinational R/S/I router. It selects the R and S operands from NSRC packed sources, constants, or a forwarded last result, and applies optional one's-complement inversion. It also generates the immediate I (0, +1, −1, or a sign-extended field). The selected operand bundle is presented to the MAC/adder stage through a valid/ready interface with a 2-entry skid buffer, so the bundle runs at full throughput under backpressure.

## Interface
- W, 24: operand width.
- NSRC, 4: data sources per operand port, ≥2, power of 2.
- IMMW, 8: immediate field width, ≤W.
- SELW, $clog2(NSRC)+2: select-code width (derived, not overridden).

Ports:
- clk  in  1  Rising-edge clock; the only clock.
- rst  in  1  Synchronous, active-high reset.
- in_valid  in  1  Control/operand bundle valid.
- in_ready  out  1  Bundle accepted when in_valid && in_ready.
- src_r  in  NSRC*W  R sources; source k is src_r[k*W +: W].
- src_s  in  NSRC*W  S sources, packed the same way.
- sel_r, sel_s  in  SELW  Operand select codes.
- inv_r, inv_s  in  1  Invert the selected operand.
- sel_i  in  2  Immediate select.
- imm  in  IMMW  Signed immediate field.
- res_valid  in  1  Write-back result valid.
- res_data  in  W  Write-back result.
- out_valid  out  1  Output bundle valid.
- out_ready  in  1  Downstream accepts.
- R, S, I  out  W  Registered operands.
- msb_r, msb_s  out  1  Equal to R[W-1] and S[W-1] in the same bundle.

## Operation
- Select codes (sel_r and sel_s share one encoding):
  - 0..NSRC-1 selects source k.
  - NSRC selects all-zeros.
  - NSRC+1 selects all-ones.
  - NSRC+2 selects the last result.
  - Any other code selects zero.
- The select is resolved first; if inv is set the result is then bitwise-inverted (~).
- Last-result register last_res (W bits):
  - Loads res_data on every cycle with res_valid=1.
  - If res_valid and an accepted bundle selecting the last result occur in the same cycle, the bundle receives the new res_data (bypass), not the old last_res.
- Immediate encoding:
  - sel_i 0 gives 0.
  - sel_i 1 gives +1.
  - sel_i 2 gives all-ones (−1).
  - sel_i 3 gives imm sign-extended to W.
- The operand bundle {R, S, I, msb_r, msb_s} is computed at input acceptance and stored as one payload.
- Skid buffer, two entries (out register + skid register):
  - in_ready = !skid_full && !rst.
  - Accept while the out register is empty, or is being drained (out_ready=1): the payload goes to the out register.
  - Accept while out_valid=1 and out_ready=0: the payload goes to the skid register and skid_full is set.
  - When skid_full=1 and out_ready=1: the skid payload moves to the out register and skid_full clears. in_ready rises the following cycle.
- Ordering is strictly FIFO. The output payload is stable while out_valid=1 and out_ready=0.

## Timing
- Latency is one cycle: a bundle accepted at edge n appears at edge n+1 when the buffer is empty.
- Throughput is one bundle per cycle while out_ready=1.
- Reset values: out_valid=0; R, S, I = 0; msb_r, msb_s = 0; last_res=0; skid_full=0.
- in_ready=0 during the cycle rst is high, and 1 on the first cycle after.
- Reset mid-operation discards both buffered entries with no output handshake.
- Full buffer (skid_full=1): in_ready=0; in_valid is ignored and no data is lost.
- Simultaneous drain and accept with skid empty: the out register reloads with the new payload and out_valid stays 1.
- res_valid is independent of both handshakes. It is honoured even when in_ready=0.

## Structure
- Package router_pkg holds:
  - Select-code constants (SEL_ZERO, SEL_ONES, SEL_LAST offsets relative to NSRC).
  - Immediate codes IMM_ZERO, IMM_P1, IMM_M1, IMM_EXT.
  - A packed payload struct/width function: 3*W+2 bits.
- One sub-module, skid_buf2: generic 2-entry valid/ready skid buffer, parameterised on payload width.
- Operand selection and inversion stay combinational in router_pipe.

## Test plan
- Exhaustive select test, W=24, NSRC=4, out_ready=1.
  - Stimulus: src_r[k] = 0x123456+k, src_s[k] = 0xABCDEF+k. Sweep every sel_r, sel_s, inv and sel_i 0..2.
  - Response: R, S, I match the code table one cycle later; msb outputs equal the operand MSBs.
- Immediate extension.
  - sel_i=3, imm=0x80 gives I=0xFFFF80.
  - sel_i=3, imm=0x7F gives I=0x00007F.
- Forwarding.
  - Cycle 0: res_valid with 0x00C0DE; accept sel_r=SEL_LAST. Response: R=0x00C0DE (bypass).
  - A later bundle with inv_r=1 and no res_valid gives R=0xFF3F21.
- Backpressure.
  - Stimulus: stream bundles 1..4; hold out_ready=0 for 3 cycles, then release.
  - Response: in_ready drops after 2 bundles are held; output order is 1,2,3,4 with no loss; payload stable while stalled.
- Reset mid-stream.
  - Stimulus: assert rst with both entries full.
  - Response: next cycle out_valid=0, R=S=I=0, last_res=0; in_ready=1 the cycle after rst deasserts.
